// File: rtl/i2c_slave_rx_if.sv
// Bus-side and receive-side signals of the I2C write receiver.
// The slave modport is the receiver; the master modport is whatever drives the bus
// and consumes received bytes.
interface i2c_slave_rx_if;
    logic       scl;       // raw bus SCL, asynchronous to clk
    logic       sda_in;    // raw bus SDA level, asynchronous to clk
    logic       sda_oe;    // 1 = pull SDA low
    logic [7:0] rx_data;   // last received data byte
    logic       rx_valid;  // one-cycle strobe for rx_data
    logic       rx_first;  // rx_valid byte is the first after the address
    logic       busy;      // transaction in progress

    modport slave (
        input  scl, sda_in,
        output sda_oe, rx_data, rx_valid, rx_first, busy
    );

    modport master (
        output scl, sda_in,
        input  sda_oe, rx_data, rx_valid, rx_first, busy
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// I2C target-side write receiver. Oversamples SCL/SDA on clk, detects START,
// repeated START and STOP, ACKs writes to SLAVE_ADDR and presents every received
// data byte as a one-cycle strobe. SDA is open-drain: only ever pulled low.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic           clk,
    input  logic           rst,
    i2c_slave_rx_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    // Synchronisers plus one "previous" stage for edge detection.
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;

    // Registered bus events; these give the fixed three-cycle pipeline from raw SCL.
    logic       start_q;
    logic       stop_q;
    logic       rise_q;
    logic       fall_q;
    logic       sda_q;

    logic       scl_s;
    logic       sda_s;
    logic       start_det;
    logic       stop_det;

    state_t     state_q,    state_d;
    logic [3:0] cnt_q,      cnt_d;
    logic [7:0] shreg_q,    shreg_d;
    logic       sda_oe_q,   sda_oe_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       armed_q,    armed_d;
    logic       busy_q,     busy_d;
    logic [7:0] shifted;

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];

    // SDA edges only count as START/STOP when SCL has been high on both samples.
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    assign shifted = {shreg_q[6:0], sda_q};

    // Bring raw SCL/SDA into the clk domain and keep the previous sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: synchroniser flops reset to 1 (idle bus level) so leaving reset
            // on a quiet bus does not look like an SDA or SCL edge.
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old value of
            // its predecessor, which is what turns this into a real shift chain.
            scl_sync <= {scl_sync[0], bus.scl};
            sda_sync <= {sda_sync[0], bus.sda_in};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    // Register the decoded bus events alongside the SDA level they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            sda_q   <= 1'b1;
        end else begin
            start_q <= start_det;
            stop_q  <= stop_det;
            rise_q  <= scl_s & ~scl_prev;
            fall_q  <= ~scl_s & scl_prev;
            sda_q   <= sda_s;
        end
    end

    // State register and all datapath registers of the receiver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shreg_q    <= 8'h00;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            armed_q    <= armed_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; START/STOP override any bit activity in the same cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned,
        // which would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_first_d = 1'b0;
        armed_d    = armed_q;
        busy_d     = busy_q;

        if (start_q) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            shreg_d  = 8'h00;
            sda_oe_d = 1'b0;
            armed_d  = 1'b0;
            busy_d   = 1'b1;
        end else if (stop_q) begin
            state_d  = IDLE;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            armed_d  = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
                ADDR: begin
                    if (rise_q && cnt_q < 4'd8) begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (fall_q && cnt_q == 4'd8) begin
                        if (shreg_q == {SLAVE_ADDR, 1'b0}) begin
                            sda_oe_d = 1'b1;
                            state_d  = ADDR_ACK;
                        end else begin
                            state_d  = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (fall_q) begin
                        sda_oe_d = 1'b0;
                        state_d  = DATA;
                        cnt_d    = 4'd0;
                        armed_d  = 1'b1;
                    end
                end
                DATA: begin
                    if (rise_q && cnt_q < 4'd8) begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = shifted;
                            rx_valid_d = 1'b1;
                            rx_first_d = armed_q;
                            armed_d    = 1'b0;
                        end
                    end else if (fall_q && cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        state_d  = DATA_ACK;
                    end
                end
                DATA_ACK: begin
                    if (fall_q) begin
                        sda_oe_d = 1'b0;
                        state_d  = DATA;
                        cnt_d    = 4'd0;
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_first = rx_first_q;
    assign bus.busy     = busy_q;

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- I2C target-side write receiver: the responder at the other end of the bus driven by the team's `i2c` master.
- Oversamples raw SCL/SDA on the system clock and detects START, repeated START and STOP.
- Shifts in the 7-bit address plus R/W bit, ACKs writes to its own address, then delivers each received data byte on a one-cycle-valid parallel interface.
- SDA is open-drain: the block only ever pulls low via `sda_oe`; the pad/tristate lives at top level.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target answers to.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  raw bus SCL; asynchronous to clk.
- sda_in  input  1  raw bus SDA level; asynchronous to clk.
- sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
- rx_data  output  8  last received data byte, MSB first on the bus.
- rx_valid  output  1  one-clk pulse; rx_data is valid this cycle.
- rx_first  output  1  qualifies rx_valid: byte is the first data byte after the address.
- busy  output  1  1 from START until STOP or abort.

Behaviour:
Reset:
- On rst=1 (async), all outputs go to 0: sda_oe=0, rx_data=8'h00, rx_valid=0, rx_first=0, busy=0.
- State = IDLE; counters and shift register cleared.
- Reset mid-transaction releases SDA immediately; the block resumes only on a new START.

Input conditioning:
- scl and sda_in each pass through a 2-flop synchroniser, then a third "previous" flop for edge detection.
- Bus requirement: each SCL high/low phase ≥ 4 clk cycles; SDA stable ≥ 4 clk cycles around SCL edges.

Bus conditions (synchronised signals):
- START: SDA falls while SCL high.
- STOP: SDA rises while SCL high.
- Data bits are sampled on the SCL rising edge.
- sda_oe changes only on the SCL falling edge.

States and transitions:
- IDLE:
  - busy=0.
  - START → ADDR (bit count 0, busy=1).
  - All other activity ignored.
- ADDR:
  - Shift 8 bits on SCL rises: A6..A0, then R/W.
  - On the falling edge after bit 8:
    - address == SLAVE_ADDR and R/W == 0 → sda_oe=1, go to ADDR_ACK.
    - otherwise → sda_oe stays 0 (NACK), go to IGNORE.
- ADDR_ACK:
  - On the next SCL falling edge (end of 9th clock): sda_oe=0, go to DATA, bit count 0, rx_first armed.
- DATA:
  - Shift 8 bits MSB first.
  - On the SCL rise of bit 8: rx_data ← byte and rx_valid=1 for exactly one clk.
  - rx_first=1 on that same cycle if armed; then disarm.
  - On the following SCL fall: sda_oe=1, go to DATA_ACK.
- DATA_ACK:
  - On the next SCL fall: sda_oe=0, return to DATA.
  - Unlimited bytes per transaction; every byte is ACKed.
- IGNORE:
  - sda_oe held 0; wait for START or STOP.

Global events:
- START in any state (repeated START) → ADDR: sda_oe=0, bit count 0, rx_first disarmed.
- STOP in any state → IDLE: sda_oe=0, busy=0.
- A partial byte at STOP or START is discarded; no rx_valid is produced.
- START/STOP detection has priority over data sampling in the same clk.

Latency and widths:
- rx_valid asserts exactly 3 clk cycles after the first clk edge that samples raw scl=1 for bit 8.
- rx_data holds its value until the next rx_valid.
- Bit counter is 4 bits and saturates at 8 within a byte; it never wraps mid-byte.

Test Plan:
- Write, matching address: rst 10 cycles; master START, addr 7'h50 W, data 8'hAA, STOP (SCL phase 8 clk).
  - sda_oe=1 during both 9th clocks.
  - Exactly one rx_valid with rx_data=8'hAA, rx_first=1.
  - busy returns 0 after STOP.
- Address mismatch: addr 7'h51 W, data 8'h55 → sda_oe never 1, no rx_valid, busy=1 until STOP.
- Read request: addr 7'h50 R → NACK (sda_oe stays 0), state IGNORE; a following STOP gives busy=0.
- Multi-byte write and abort:
  - Bytes 8'h01, 8'h02, 8'hFF → three rx_valid pulses, rx_first only on 8'h01, ACK after each.
  - Then repeated START mid-byte (after 4 bits): no rx_valid; new addr 7'h50 W is ACKed.
- Reset mid-ACK: assert rst while sda_oe=1 → sda_oe=0 within the same cycle (async); later traffic is ignored until a fresh START.
- Latency check: for byte 8'hAA, measure rx_valid at exactly 3 clk after raw scl rise of bit 8; rx_valid width = 1 clk.
